fetch_sequencer: RTL and testbench

Upstream fetch stage of the nic8 CPU: owns the program counter (PC), instruction register (IR) and the fetch/execute phase machine, and presents `ir` to the instruction decoder. It consumes the decoder's `loadBarIR`, `assertRom` and `doJumpBar` strobes to decide the next PC, IR and phase. It also detects the jump-to-self idiom and reports a halt.

---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch stage of the nic8 CPU. Owns the program counter, the instruction
//   register and the fetch/execute phase machine. Consumes the decoder's
//   strobes during EXEC to choose the next PC/IR/phase, and freezes when an
//   instruction jumps to its own address (halt idiom).
//
// Ports
//   clk        system clock, rising-edge
//   reset      synchronous, active-high
//   run        1 = advance, 0 = hold in FETCH
//   romData    ROM output at address pc
//   bus        data bus during EXEC (jump target / IR-load source)
//   loadBarIR  active-low: instruction destination is IR
//   assertRom  active-high: instruction consumes an immediate from ROM
//   doJumpBar  active-low: instruction takes a jump
//   pc         ROM address
//   ir         current instruction to the decoder
//   execPhase  0 = FETCH, 1 = EXEC
//   instrAddr  address the current ir was fetched from
//   halted     jump-to-self detected, sequencer frozen
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | latch romData into ir, advance pc (or hold while run = 0)
// EXEC  | apply decoder strobes: jump / immediate / IR reload
// HALT  | jump-to-self seen; everything frozen until reset

module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] romData,
    input  logic [7:0] bus,
    input  logic       loadBarIR,
    input  logic       assertRom,
    input  logic       doJumpBar,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       execPhase,
    output logic [7:0] instrAddr,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seqState_e;

    seqState_e  state;
    seqState_e  stateNext;
    logic [7:0] pcNext;
    logic [7:0] irNext;
    logic [7:0] instrAddrNext;
    logic       jumpTaken;
    logic       selfJump;

    assign jumpTaken = ~doJumpBar;
    // Halt compares against the instruction's own address, not pc, so an
    // immediate-operand jump back to itself is caught as well.
    assign selfJump  = jumpTaken && (bus == instrAddr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= 8'h00;
            instrAddr <= 8'h00;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            ir        <= irNext;
            instrAddr <= instrAddrNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        irNext        = ir;
        instrAddrNext = instrAddr;
        case (state)
            FETCH: begin
                if (run) begin
                    irNext        = romData;
                    instrAddrNext = pc;
                    pcNext        = pc + 8'd1;
                    stateNext     = EXEC;
                end
            end
            EXEC: begin
                if (selfJump) begin
                    stateNext = HALT;
                end else begin
                    // A jump wins over an immediate increment.
                    if (jumpTaken) begin
                        pcNext = bus;
                    end else if (assertRom) begin
                        pcNext = pc + 8'd1;
                    end
                    // IR reload: the loaded byte executes next cycle with
                    // no ROM fetch; it is attributed to the pre-update pc.
                    if (!loadBarIR) begin
                        irNext        = bus;
                        instrAddrNext = pc;
                    end else begin
                        stateNext = FETCH;
                    end
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign execPhase = (state == EXEC);
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] romData;
    logic [7:0] bus;
    logic       loadBarIR;
    logic       assertRom;
    logic       doJumpBar;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       execPhase;
    logic [7:0] instrAddr;
    logic       halted;

    logic [7:0] rom [0:255];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the sequencer.
    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;
    logic [7:0] mPc, mIr, mAddr;
    int         mPhase;

    always #5 clk = ~clk;

    assign romData = rom[pc];

    fetch_sequencer #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .romData   (romData),
        .bus       (bus),
        .loadBarIR (loadBarIR),
        .assertRom (assertRom),
        .doJumpBar (doJumpBar),
        .pc        (pc),
        .ir        (ir),
        .execPhase (execPhase),
        .instrAddr (instrAddr),
        .halted    (halted)
    );

    // Advance the model by one instruction-phase from the current inputs,
    // then let the DUT take the same edge. Outputs are sampled 1 time unit
    // after the edge.
    task automatic tick();
        logic [7:0] nPc, nIr, nAddr;
        int nPhase;
        nPc = mPc; nIr = mIr; nAddr = mAddr; nPhase = mPhase;
        if (reset) begin
            nPc = 8'h00; nIr = 8'h00; nAddr = 8'h00; nPhase = PH_FETCH;
        end else if (mPhase == PH_FETCH) begin
            if (run) begin
                nIr = rom[mPc]; nAddr = mPc; nPc = mPc + 8'd1; nPhase = PH_EXEC;
            end
        end else if (mPhase == PH_EXEC) begin
            if (!doJumpBar && bus == mAddr) begin
                nPhase = PH_HALT;
            end else begin
                if (!doJumpBar) nPc = bus;
                else if (assertRom) nPc = mPc + 8'd1;
                if (!loadBarIR) begin
                    nIr = bus; nAddr = mPc;
                end else begin
                    nPhase = PH_FETCH;
                end
            end
        end
        @(posedge clk);
        #1;
        mPc = nPc; mIr = nIr; mAddr = nAddr; mPhase = nPhase;
    endtask

    task automatic idleStrobes();
        loadBarIR = 1'b1; assertRom = 1'b0; doJumpBar = 1'b1; bus = 8'h00;
    endtask

    // Reset, then jump so that the sequencer sits in EXEC with pc == want
    // and instrAddr == want-1. want must not be 8'h01.
    task automatic gotoExec(input logic [7:0] want);
        run = 1'b1; idleStrobes();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        doJumpBar = 1'b0; bus = want - 8'd1; tick();
        idleStrobes(); tick();
    endtask

    task automatic test_reset();
        rom[0] = 8'h2C;
        run = 1'b1; idleStrobes();
        reset = 1'b1; tick(); tick();
        checks++;
        if (pc !== 8'h00 || ir !== 8'h00 || execPhase !== 1'b0 || halted !== 1'b0 || instrAddr !== 8'h00) begin
            errors++;
            $display("FAIL reset: pc=%h ir=%h exec=%b halted=%b ia=%h, want 00 00 0 0 00", pc, ir, execPhase, halted, instrAddr);
        end
        reset = 1'b0; tick();
        checks++;
        if (ir !== 8'h2C || pc !== 8'h01 || execPhase !== 1'b1 || instrAddr !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch: ir=%h pc=%h exec=%b ia=%h, want 2c 01 1 00", ir, pc, execPhase, instrAddr);
        end
        tick();
        checks++;
        if (execPhase !== 1'b0 || pc !== 8'h01) begin
            errors++;
            $display("FAIL first_exec: exec=%b pc=%h, want 0 01", execPhase, pc);
        end
    endtask

    task automatic test_immediate_wrap();
        gotoExec(8'hFF);
        checks++;
        if (pc !== 8'hFF || instrAddr !== 8'hFE || execPhase !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fetch: pc=%h ia=%h exec=%b, want ff fe 1", pc, instrAddr, execPhase);
        end
        assertRom = 1'b1; tick();
        checks++;
        if (pc !== 8'h00 || execPhase !== 1'b0 || instrAddr !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_exec: pc=%h exec=%b ia=%h, want 00 0 fe", pc, execPhase, instrAddr);
        end
        idleStrobes();
    endtask

    task automatic test_jump_priority();
        gotoExec(8'h11);
        rom[8'h40] = 8'h5D;
        doJumpBar = 1'b0; assertRom = 1'b1; bus = 8'h40; tick();
        checks++;
        if (pc !== 8'h40 || execPhase !== 1'b0) begin
            errors++;
            $display("FAIL jump_pc: pc=%h exec=%b, want 40 0", pc, execPhase);
        end
        idleStrobes(); tick();
        checks++;
        if (ir !== 8'h5D || instrAddr !== 8'h40 || pc !== 8'h41) begin
            errors++;
            $display("FAIL jump_fetch: ir=%h ia=%h pc=%h, want 5d 40 41", ir, instrAddr, pc);
        end
    endtask

    task automatic test_ir_load();
        gotoExec(8'h05);
        loadBarIR = 1'b0; bus = 8'h9A; doJumpBar = 1'b1; assertRom = 1'b0; tick();
        checks++;
        if (ir !== 8'h9A || execPhase !== 1'b1 || instrAddr !== 8'h05 || pc !== 8'h05) begin
            errors++;
            $display("FAIL ir_load: ir=%h exec=%b ia=%h pc=%h, want 9a 1 05 05", ir, execPhase, instrAddr, pc);
        end
        // Simultaneous reload and jump: both apply, still EXEC.
        loadBarIR = 1'b0; doJumpBar = 1'b0; bus = 8'h77; tick();
        checks++;
        if (ir !== 8'h77 || pc !== 8'h77 || execPhase !== 1'b1 || instrAddr !== 8'h05) begin
            errors++;
            $display("FAIL load_jump: ir=%h pc=%h exec=%b ia=%h, want 77 77 1 05", ir, pc, execPhase, instrAddr);
        end
        idleStrobes(); tick();
    endtask

    task automatic test_halt();
        gotoExec(8'h21);
        assertRom = 1'b1; doJumpBar = 1'b0; bus = 8'h20; tick();
        checks++;
        if (halted !== 1'b1 || execPhase !== 1'b0 || pc !== 8'h21) begin
            errors++;
            $display("FAIL halt_enter: halted=%b exec=%b pc=%h, want 1 0 21", halted, execPhase, pc);
        end
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus = 8'($urandom); doJumpBar = 1'($urandom); assertRom = 1'($urandom);
            loadBarIR = 1'($urandom);
            tick();
            checks++;
            if (halted !== 1'b1 || pc !== 8'h21 || execPhase !== 1'b0 || ir !== mIr) begin
                errors++;
                $display("FAIL halt_hold[%0d]: halted=%b pc=%h exec=%b ir=%h, want 1 21 0 %h", i, halted, pc, execPhase, ir, mIr);
            end
        end
        idleStrobes();
        reset = 1'b1; tick();
        checks++;
        if (halted !== 1'b0 || pc !== 8'h00 || execPhase !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h exec=%b, want 0 00 0", halted, pc, execPhase);
        end
        reset = 1'b0;
    endtask

    task automatic test_pause();
        gotoExec(8'h07);
        rom[8'h07] = 8'hA5;
        run = 1'b0; tick();
        checks++;
        if (execPhase !== 1'b0 || pc !== 8'h07) begin
            errors++;
            $display("FAIL pause_exec_done: exec=%b pc=%h, want 0 07", execPhase, pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (execPhase !== 1'b0 || pc !== 8'h07 || instrAddr !== 8'h06) begin
                errors++;
                $display("FAIL pause_hold[%0d]: exec=%b pc=%h ia=%h, want 0 07 06", i, execPhase, pc, instrAddr);
            end
        end
        run = 1'b1; tick();
        checks++;
        if (ir !== 8'hA5 || instrAddr !== 8'h07 || execPhase !== 1'b1 || pc !== 8'h08) begin
            errors++;
            $display("FAIL pause_resume: ir=%h ia=%h exec=%b pc=%h, want a5 07 1 08", ir, instrAddr, execPhase, pc);
        end
        idleStrobes(); tick();
    endtask

    task automatic test_random();
        run = 1'b1; idleStrobes();
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(99) == 0);
            run       = ($urandom_range(9) != 0);
            loadBarIR = ($urandom_range(3) != 0);
            assertRom = 1'($urandom);
            doJumpBar = ($urandom_range(2) != 0);
            // Bias the bus toward the current instruction address so halts occur.
            bus       = ($urandom_range(15) == 0) ? mAddr : 8'($urandom);
            tick();
            checks++;
            if (pc !== mPc || ir !== mIr || instrAddr !== mAddr ||
                execPhase !== (mPhase == PH_EXEC) || halted !== (mPhase == PH_HALT)) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h ir=%h ia=%h exec=%b halted=%b, want %h %h %h %b %b",
                         i, pc, ir, instrAddr, execPhase, halted, mPc, mIr, mAddr,
                         (mPhase == PH_EXEC), (mPhase == PH_HALT));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        mPc = 8'h00; mIr = 8'h00; mAddr = 8'h00; mPhase = PH_FETCH;
        reset = 1'b1; run = 1'b0; idleStrobes();
        test_reset();
        test_immediate_wrap();
        test_jump_priority();
        test_ir_load();
        test_halt();
        test_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
